// File: rtl/line_overlay_multi.sv
// Multi-segment Bresenham line overlay on the VGA raster. Each line's engine builds
// the x-span of the next row while the current row is scanned. Spans are double-buffered.
module line_overlay_multi #(
  parameter int          NUM_LINES = 2,
  parameter int          XW        = 11,
  parameter int          YW        = 10,
  parameter int          HTOTAL    = 1056,
  parameter int          VTOTAL    = 525,
  parameter logic [23:0] BG_COLOR  = 24'h5646EF
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic [XW-1:0]        x_cnt,
  input  logic [YW-1:0]        y_cnt,
  input  logic                 x_period,
  input  logic                 y_period,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_sel,
  input  logic [XW-1:0]        cfg_x0,
  input  logic [XW-1:0]        cfg_x1,
  input  logic [YW-1:0]        cfg_y0,
  input  logic [YW-1:0]        cfg_y1,
  input  logic [23:0]          cfg_color,
  input  logic                 cfg_en,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 curseur,
  output logic [NUM_LINES-1:0] hit_mask,
  output logic                 overrun,
  output logic                 frame_start
);
  localparam int CW  = (XW > YW) ? XW : YW;
  localparam int EW  = CW + 2;
  localparam int E2W = EW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP} state_t;

  logic                 w_fb, w_x0, w_xlast;
  logic [YW-1:0]        w_r;
  logic [NUM_LINES-1:0] w_hit, w_ovr_v;
  logic [23:0]          w_lcol [NUM_LINES];
  logic [23:0]          w_col;

  assign w_fb        = (x_cnt == '0) && (y_cnt == YW'(VTOTAL - 1));
  assign w_x0        = (x_cnt == '0);
  assign w_xlast     = (x_cnt == XW'(HTOTAL - 1));
  assign w_r         = (y_cnt == YW'(VTOTAL - 1)) ? '0 : y_cnt + 1'b1;
  assign frame_start = w_fb;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [XW-1:0]        r_sx0, r_sx1;
    logic [YW-1:0]        r_sy0, r_sy1;
    logic [23:0]          r_scol;
    logic                 r_sen;
    logic [XW-1:0]        r_x0, r_x1, r_dx;
    logic [YW-1:0]        r_y0, r_y1, r_dy;
    logic                 r_sxn, r_en;
    logic [23:0]          r_col;
    logic signed [EW-1:0] r_err0, r_err;
    state_t               r_st, w_st_nxt;
    logic [XW-1:0]        r_cx, r_nlo, r_nhi, r_alo, r_ahi;
    logic [YW-1:0]        r_cy, r_tr;
    logic                 r_done, r_nv, r_av;
    logic                 w_swap, w_in, w_atend, w_xs, w_ys, w_stend, w_ovr, w_dec;
    logic [XW-1:0]        w_nx0, w_nx1, w_ndx, w_dcx, w_nx;
    logic [YW-1:0]        w_ny0, w_ny1, w_ndy, w_dcy, w_ny;
    logic signed [EW-1:0] w_dxe, w_dye, w_err_s;
    logic signed [E2W-1:0] w_e2;

    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
        r_sx0 <= '0; r_sx1 <= '0; r_sy0 <= '0; r_sy1 <= '0; r_scol <= '0; r_sen <= 1'b0;
      end else if (cfg_we && cfg_sel == 3'(g)) begin
        r_sx0 <= cfg_x0; r_sx1 <= cfg_x1; r_sy0 <= cfg_y0; r_sy1 <= cfg_y1;
        r_scol <= cfg_color; r_sen <= cfg_en;
      end
    end

    // Normalise the staged segment so the engine always walks downward in y
    assign w_swap = r_sy0 > r_sy1;
    assign w_nx0  = w_swap ? r_sx1 : r_sx0;
    assign w_nx1  = w_swap ? r_sx0 : r_sx1;
    assign w_ny0  = w_swap ? r_sy1 : r_sy0;
    assign w_ny1  = w_swap ? r_sy0 : r_sy1;
    assign w_ndx  = (w_nx1 >= w_nx0) ? w_nx1 - w_nx0 : w_nx0 - w_nx1;
    assign w_ndy  = w_ny1 - w_ny0;

    // LOAD makes the row-0 decision itself, from the freshly loaded shadow
    assign w_dcx   = (r_st == S_LOAD) ? r_x0 : r_cx;
    assign w_dcy   = (r_st == S_LOAD) ? r_y0 : r_cy;
    assign w_dec   = (r_st == S_LOAD) || (r_st == S_WAIT && w_x0);
    assign w_in    = r_en && (w_r >= r_y0) && (w_r <= r_y1) && (w_dcy == w_r) &&
                     ((r_st == S_LOAD) || !r_done);
    assign w_atend = (w_dcx == r_x1) && (w_dcy == r_y1);

    assign w_dxe = $signed(EW'(r_dx));
    assign w_dye = $signed(EW'(r_dy));
    assign w_e2  = {r_err, 1'b0};
    assign w_xs  = (w_e2 >= -w_dye);
    assign w_ys  = (w_e2 <= w_dxe);
    assign w_nx  = w_xs ? (r_sxn ? r_cx - 1'b1 : r_cx + 1'b1) : r_cx;
    assign w_ny  = w_ys ? r_cy + 1'b1 : r_cy;
    assign w_stend = (w_nx == r_x1) && (w_ny == r_y1) && (w_ny == r_tr);

    always_comb begin
      w_err_s = r_err;
      if (w_xs) w_err_s = w_err_s - w_dye;
      if (w_ys) w_err_s = w_err_s + w_dxe;
    end

    always_comb begin
      w_st_nxt = r_st;
      w_ovr    = 1'b0;
      if (w_fb) w_st_nxt = S_LOAD;
      else begin
        case (r_st)
          S_LOAD: w_st_nxt = (w_in && !w_atend) ? S_STEP : S_WAIT;
          S_WAIT: if (w_dec && w_in && !w_atend) w_st_nxt = S_STEP;
          S_STEP: begin
            if (w_xlast) begin
              w_st_nxt = S_WAIT;
              w_ovr    = 1'b1;
            end else if (w_ny > r_tr || w_stend) w_st_nxt = S_WAIT;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) r_st <= S_IDLE;
      else         r_st <= w_st_nxt;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
        r_x0 <= '0; r_x1 <= '0; r_dx <= '0; r_y0 <= '0; r_y1 <= '0; r_dy <= '0;
        r_sxn <= 1'b0; r_en <= 1'b0; r_col <= '0; r_err0 <= '0; r_err <= '0;
        r_cx <= '0; r_cy <= '0; r_tr <= '0; r_done <= 1'b0;
        r_nv <= 1'b0; r_nlo <= '0; r_nhi <= '0; r_av <= 1'b0; r_alo <= '0; r_ahi <= '0;
      end else begin
        if (w_fb) begin
          r_x0 <= w_nx0; r_x1 <= w_nx1; r_y0 <= w_ny0; r_y1 <= w_ny1;
          r_dx <= w_ndx; r_dy <= w_ndy; r_sxn <= (w_nx1 < w_nx0);
          r_err0 <= $signed(EW'(w_ndx)) - $signed(EW'(w_ndy));
          r_col <= r_scol; r_en <= r_sen;
        end
        if (w_xlast) begin
          r_av <= r_nv; r_alo <= r_nlo; r_ahi <= r_nhi;
        end
        if (w_dec) begin
          r_cx <= w_dcx; r_cy <= w_dcy; r_tr <= w_r;
          r_nv <= w_in; r_nlo <= w_dcx; r_nhi <= w_dcx;
          if (r_st == S_LOAD) begin
            r_err  <= r_err0;
            r_done <= 1'b0;
          end
          if (w_in && w_atend) r_done <= 1'b1;
        end else if (r_st == S_STEP && !w_xlast) begin
          r_cx <= w_nx; r_cy <= w_ny; r_err <= w_err_s;
          if (w_ny == r_tr) begin
            if (w_nx < r_nlo) r_nlo <= w_nx;
            if (w_nx > r_nhi) r_nhi <= w_nx;
          end
          if (w_stend) r_done <= 1'b1;
        end
      end
    end

    assign w_hit[g]   = r_av && (x_cnt >= r_alo) && (x_cnt <= r_ahi);
    assign w_lcol[g]  = r_col;
    assign w_ovr_v[g] = w_ovr;
  end

  always_comb begin
    w_col = BG_COLOR;
    for (int i = NUM_LINES - 1; i >= 0; i--) if (w_hit[i]) w_col = w_lcol[i];
  end

  logic [23:0]          r_rgb;
  logic [NUM_LINES-1:0] r_hit;
  logic                 r_cur, r_ovr;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_rgb <= '0; r_hit <= '0; r_cur <= 1'b0; r_ovr <= 1'b0;
    end else begin
      r_rgb <= (x_period && y_period) ? w_col : 24'h0;
      r_hit <= w_hit;
      r_cur <= |w_hit;
      if (|w_ovr_v) r_ovr <= 1'b1;
    end
  end

  assign red      = r_rgb[23:16];
  assign green    = r_rgb[15:8];
  assign blue     = r_rgb[7:0];
  assign hit_mask = r_hit;
  assign curseur  = r_cur;
  assign overrun  = r_ovr;
endmodule

// File: doc/line_overlay_multi.md
Name: line_overlay_multi

Overview:
- Parametrised multi-segment line renderer for the VGA pipeline, driven by the raster counters of the x/y counter block.
- Draws NUM_LINES arbitrary oblique segments, each with its own RGB colour, over a background colour, at pixel rate.
- Each line has a Bresenham engine. The engine computes the x-span for the next raster row while the current row is scanned; spans are double-buffered.
- Segment endpoints and colours are written via a config port and take effect at the next frame boundary.

Parameters:
NUM_LINES  2  number of independent line segments (1..8)
XW  11  x coordinate / counter width
YW  10  y coordinate / counter width
HTOTAL  1056  pixel clocks per row (x_cnt wraps at HTOTAL-1)
VTOTAL  525  rows per frame (y_cnt wraps at VTOTAL-1)
BG_COLOR  24'h5646EF  background {R,G,B}

Ports:
iCLK  in  1  pixel clock
iRST_n  in  1  asynchronous active-low reset
x_cnt  in  XW  raster x from counter block
y_cnt  in  YW  raster y from counter block
x_period  in  1  horizontal active video
y_period  in  1  vertical active video
cfg_we  in  1  config write strobe, single cycle
cfg_sel  in  3  line index (values >= NUM_LINES ignored)
cfg_x0, cfg_x1  in  XW  endpoint x
cfg_y0, cfg_y1  in  YW  endpoint y
cfg_color  in  24  {R,G,B} of line
cfg_en  in  1  line enable
red, green, blue  out  8 each  pixel colour, registered
curseur  out  1  any enabled line covers the current pixel, registered
hit_mask  out  NUM_LINES  per-line coverage, registered
overrun  out  1  sticky: an engine failed to finish a span within one row
frame_start  out  1  single-cycle pulse when shadow config is loaded

Behaviour:
- Reset: all outputs 0; staging and shadow config 0 with all lines disabled; engines IDLE; spans invalid.
- Config:
  - cfg_we writes the staging registers of line cfg_sel in one cycle; no backpressure.
  - Staging is copied to shadow when x_cnt==0 and y_cnt==VTOTAL-1; frame_start pulses that cycle.
  - A write in that same cycle lands in staging only and takes effect the following frame.
- Normalisation at shadow load:
  - If y0>y1, endpoints are swapped.
  - dx=|x1-x0|, dy=y1-y0, sx=+1 if x1>=x0 else -1.
  - err=dx-dy, signed, width max(XW,YW)+2.
- Engine FSM, per line:
  - IDLE -> LOAD on shadow load.
  - LOAD: cur=(x0,y0); -> WAIT.
  - WAIT: at x_cnt==0, target row r = (y_cnt+1) mod VTOTAL. If line disabled or r<y0 or r>y1 or DONE set, the next span is empty. Else if cur_y==r -> STEP with lo=hi=cur_x, otherwise the next span is empty.
  - STEP: one Bresenham step per clock.
    - e2=2*err.
    - If e2>=-dy: err-=dy, cur_x+=sx.
    - If e2<=dx: err+=dx, cur_y+=1.
    - Update lo/hi with the new cur_x only while cur_y still equals r.
    - Exit to WAIT when cur_y>r; set DONE when (cur_x,cur_y)==(x1,y1).
  - If STEP is still active at x_cnt==HTOTAL-1: set overrun, force exit to WAIT, and commit the partial span.
- Span commit: at x_cnt==HTOTAL-1 the next span (valid,lo,hi) moves to the active span for the row starting next cycle.
- Pixel path:
  - hit[i] = active_valid[i] & lo[i]<=x_cnt<=hi[i].
  - Registered 1 cycle: hit_mask, curseur=|hit.
  - Colour = lowest-index hitting line, else BG_COLOR.
  - Colour forced to 0 when !(x_period&y_period).
- Degenerate cases:
  - Point line (x0==x1, y0==y1): one pixel on row y0.
  - Horizontal line (dy==0): full span min(x0,x1)..max(x0,x1) on one row.
  - Vertical line: one pixel per row.
- iRST_n assertion mid-frame clears everything immediately. Lines draw again only after re-configuration and the next frame boundary.
- overrun clears only on reset.

Test Plan:
- Line0 (100,0)-(100,9), red 0xFF0000, enabled: after frame boundary, rows 0..9 show hit at x=100 only; red=FF one cycle after x_cnt=100; other pixels 56/46/EF.
- Line0 (10,5)-(20,15) at 45°: row 5+k hits exactly x=10+k, k=0..10; no hits rows 4, 16.
- Line0 (40,20)-(10,23), swapped endpoints: rows 20..23 spans are contiguous, descending, and cover x 10..40 with no gaps; overrun stays 0.
- Line0 (50,30)-(50,30) and line1 (0,30)-(99,30): row 30 hit_mask=2'b11 at x=50 and shows line0 colour; x=0..99 otherwise shows line1 colour.
- Write line0 with cfg_we mid-frame at y_cnt=200: current frame is unchanged; new geometry appears after frame_start.
- Drop iRST_n at y_cnt=5 mid-frame: outputs 0 immediately; after release without config, only background is drawn, curseur stays 0.
